btn_conditioner: RTL and testbench
==================================

# btn_conditioner

Two-channel push-button front end for the XOR network board. It synchronises and debounces the raw `btn_1`/`btn_2` pins and turns each press into a clean XOR operand bit (`x_1`, `x_2`). It also raises a one-cycle `x_valid` strobe so the display stage re-evaluates and refreshes only when an operand changes. It sits directly upstream of the display stage, between the board pins and the network/display logic.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable synchronised cycles (10 ms at 50 MHz) required to accept a new button level; minimum 1.
- `SYNC_STAGES`, default 2: synchroniser depth per button; minimum 2.
- `clk`  in  1  system clock.
- `rst`  in  1  reset. One clock; reset is asynchronous and active-high.
- `btn_1`  in  1  raw button 1, asynchronous, active-high.
- `btn_2`  in  1  raw button 2, asynchronous, active-high.
- `x_1`  out  1  XOR operand A.
- `x_2`  out  1  XOR operand B.
- `press_1`  out  1  one-cycle pulse per accepted press of button 1.
- `press_2`  out  1  one-cycle pulse per accepted press of button 2.
- `x_valid`  out  1  one-cycle pulse in the first cycle a new `{x_1,x_2}` is visible.

## Operation
- **Per channel pipeline:** synchroniser → debounce counter → stable level → edge detect.
- **Synchroniser:** `SYNC_STAGES` flops, all reset to 0.
- **Debounce counter:**
  - Width is `$clog2(DEBOUNCE_CYCLES)`, with a minimum of 1.
  - While the synchronised level equals `stable`, the counter holds 0.
  - While they differ, it increments every cycle.
  - When the counter equals `DEBOUNCE_CYCLES-1`, then on that edge `stable` takes the synchronised level and the counter clears.
  - Any single-cycle return to `stable` clears the counter, so a bounce restarts the count.
  - The counter never exceeds `DEBOUNCE_CYCLES-1`; no wrap-around.
- **Press detect:** `press_n` is registered and equals `stable_n & ~stable_n_d`. Releases produce no pulse.
- **Operand update:** on `press_n`, `x_n` is updated per Configuration. Both channels update independently in the same cycle when pressed together.
- **Strobe:** `x_valid` is asserted for exactly one cycle whenever `x_1` or `x_2` changed on the previous edge. A simultaneous change of both bits yields a single pulse.
- **Reset values:**
  - All outputs 0.
  - Counters 0; `stable` and `stable_d` 0.
  - Asserting `rst` mid-count or mid-pulse discards all progress. No pulse is emitted at or after reset deassertion unless a fresh full debounce completes.
- A button held high through reset deassertion is treated as a new press after the full latency.

## Timing
- **Press latency:** raw edge at cycle 0 with the input then steady:
  - `stable` changes at edge `SYNC_STAGES + DEBOUNCE_CYCLES`.
  - `press_n` and the new `x_n` appear at edge `SYNC_STAGES + DEBOUNCE_CYCLES + 1`.
- **`x_valid` timing:** high in the same cycle the new `x_n` value is first visible, that is, the same cycle as `press_n` in toggle mode.
- **Release latency (level mode):** `x_n` falls at edge `SYNC_STAGES + DEBOUNCE_CYCLES + 1`, with `x_valid` high in that same cycle.
- Pulses are exactly one cycle wide.
- **Minimum repeat interval:** two accepted presses on one channel are at least `2*DEBOUNCE_CYCLES` cycles apart, because each press needs an accepted release in between.

## Configuration
- **Macro:** `BTN_COND_TOGGLE_EN`.
- **Defined:** each accepted press inverts `x_n`, so the operand latches after the button is released. Releases do not change `x_n`.
- **Undefined:** `x_n` follows `stable_n` one cycle late (`x_n <= stable_n`), so the operand is 1 only while the button is held. `x_valid` then fires on both press and release. The `press_n` pulses behave identically in both builds.

## Structure
- **Shared package/include:** default `DEBOUNCE_CYCLES` and `SYNC_STAGES` constants, shared with the display stage so both use the same clock-rate assumptions.
- **Sub-module `btn_debounce_ch`:** synchroniser, debounce counter, `stable`, and registered `press` output. It is instantiated twice.
- **Top level:** holds the `x_n` update logic, the `x_valid` generation and the `BTN_COND_TOGGLE_EN` selection.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=4` and `SYNC_STAGES=2`.
1. **Reset:** assert `rst` asynchronously mid-cycle → all outputs go to 0 immediately; they stay 0 for 20 cycles after release with buttons low.
2. **Clean press:** `btn_1` rises at cycle 0 and is held 20 cycles (toggle build) → `press_1` and `x_valid` high only in cycle 7, `x_1`=1 from cycle 7. Releasing it → no change to `x_1` and no `x_valid`.
3. **Bounce rejection:** `btn_1` toggles every 2 cycles for 12 cycles, then stays 1 → exactly one `press_1`, at (last rising edge + 7). No pulse during bouncing.
4. **Simultaneous press:** `btn_1` and `btn_2` rise in the same cycle → `press_1` and `press_2` both in cycle 7, `{x_1,x_2}` goes 00→11, single `x_valid`. A second press of `btn_1` alone → `{x_1,x_2}` goes 11→01 with one `x_valid`.
5. **Level build:** without `BTN_COND_TOGGLE_EN`, press then release `btn_2` after 10 cycles → `x_2` rises at cycle 7 and falls at cycle 17, with `x_valid` in cycles 7 and 17.
6. **Reset mid-count:** assert `rst` when the `btn_1` counter reaches 3, release it next cycle with `btn_1` still high → no pulse until a full 7-cycle latency elapses after release.

Source files
------------

// File: rtl/btn_conditioner_pkg.sv
// btn_conditioner_pkg
// Purpose: board-level timing defaults for the push-button front end.
//          Also holds the per-channel status payload and a counter sizing helper.
//          The display stage imports the same defaults, so both blocks
//          share one clock-rate assumption.
// Contents:
//   DEFAULT_DEBOUNCE_CYCLES  stable cycles required to accept a level (10 ms @ 50 MHz)
//   DEFAULT_SYNC_STAGES      synchroniser depth per button
//   ch_status_t              debounced level and registered press pulse of one channel
//   cnt_width()              debounce counter width, never below 1
package btn_conditioner_pkg;

  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 500000;
  localparam int unsigned DEFAULT_SYNC_STAGES     = 2;

  // Per-channel result handed from the debouncer to the operand logic.
  typedef struct packed {
    logic stable;  // accepted (debounced) button level
    logic press;   // one-cycle pulse, registered, on each accepted rising level
  } ch_status_t;

  // $clog2(1) is 0, so clamp to a single bit for the degenerate case.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles > 1) ? $unsigned($clog2(cycles)) : 32'd1;
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// btn_debounce_ch
// Purpose: one button channel: synchroniser, debounce counter, accepted
//          level and registered press pulse.
// Parameters:
//   DEBOUNCE_CYCLES  consecutive differing synchronised cycles needed to accept a level (>= 1)
//   SYNC_STAGES      synchroniser flops (>= 2)
// Ports:
//   clk     in   system clock
//   rst     in   asynchronous active-high reset
//   btn     in   raw asynchronous button pin, active-high
//   status  out  {stable, press}; both fields are flop outputs
module btn_debounce_ch
  import btn_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned SYNC_STAGES     = DEFAULT_SYNC_STAGES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn,
  output ch_status_t status
);

  localparam int unsigned      CNT_W   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic [CNT_W-1:0]       cnt_q;
  logic                   stable_q;
  logic                   stable_d_q;
  logic                   press_q;

  assign synced = sync_q[SYNC_STAGES-1];

  // Metastability synchroniser; bit 0 faces the pin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
    end
  end

  // Debounce: count consecutive cycles the synchronised level disagrees with
  // the accepted level. Any agreeing cycle restarts the count, and reaching
  // CNT_MAX accepts the new level on that same edge, so the count saturates
  // at CNT_MAX without ever wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else if (synced == stable_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_q    <= '0;
      stable_q <= synced;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Rising-level detect on the accepted level; releases never pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_d_q <= 1'b0;
      press_q    <= 1'b0;
    end else begin
      stable_d_q <= stable_q;
      press_q    <= stable_q & ~stable_d_q;
    end
  end

  assign status.stable = stable_q;
  assign status.press  = press_q;

endmodule

// File: rtl/btn_conditioner.sv
// btn_conditioner
// Purpose: two-channel push-button front end for the XOR network board.
//          Debounces btn_1/btn_2 into XOR operands x_1/x_2. It also raises a
//          one-cycle x_valid whenever either operand changes, so the display
//          stage refreshes only on real updates.
// Build option:
//   BTN_COND_TOGGLE_EN defined   : each accepted press inverts its operand (latching)
//   BTN_COND_TOGGLE_EN undefined : operand follows the debounced level one cycle late
// Parameters:
//   DEBOUNCE_CYCLES  consecutive stable synchronised cycles to accept a level (>= 1)
//   SYNC_STAGES      synchroniser depth per button (>= 2)
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous active-high reset
//   btn_1    in   raw button 1, asynchronous, active-high
//   btn_2    in   raw button 2, asynchronous, active-high
//   x_1      out  XOR operand A
//   x_2      out  XOR operand B
//   press_1  out  one-cycle pulse per accepted press of button 1
//   press_2  out  one-cycle pulse per accepted press of button 2
//   x_valid  out  one-cycle pulse in the first cycle a new {x_1,x_2} is visible
module btn_conditioner
  import btn_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned SYNC_STAGES     = DEFAULT_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_1,
  input  logic btn_2,
  output logic x_1,
  output logic x_2,
  output logic press_1,
  output logic press_2,
  output logic x_valid
);

  ch_status_t st_1;
  ch_status_t st_2;

  logic x_1_q;
  logic x_2_q;
  logic x_valid_q;
  logic x_1_nxt_c;
  logic x_2_nxt_c;

  btn_debounce_ch #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SYNC_STAGES     (SYNC_STAGES)
  ) u_ch_1 (
    .clk    (clk),
    .rst    (rst),
    .btn    (btn_1),
    .status (st_1)
  );

  btn_debounce_ch #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SYNC_STAGES     (SYNC_STAGES)
  ) u_ch_2 (
    .clk    (clk),
    .rst    (rst),
    .btn    (btn_2),
    .status (st_2)
  );

`ifdef BTN_COND_TOGGLE_EN
  // The operand must flip on the same edge that press rises, so the rising
  // level is recomputed here from the accepted level rather than taken from
  // the already-registered press pulse.
  logic stable_1_d_q;
  logic stable_2_d_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_1_d_q <= 1'b0;
      stable_2_d_q <= 1'b0;
    end else begin
      stable_1_d_q <= st_1.stable;
      stable_2_d_q <= st_2.stable;
    end
  end

  always_comb begin
    x_1_nxt_c = x_1_q ^ (st_1.stable & ~stable_1_d_q);
    x_2_nxt_c = x_2_q ^ (st_2.stable & ~stable_2_d_q);
  end
`else
  // Level mode: operand is the accepted button level, delayed one cycle.
  always_comb begin
    x_1_nxt_c = st_1.stable;
    x_2_nxt_c = st_2.stable;
  end
`endif

  // Operand registers; x_valid marks the first cycle a changed pair is visible.
  // Both channels changing together still give a single pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_1_q     <= 1'b0;
      x_2_q     <= 1'b0;
      x_valid_q <= 1'b0;
    end else begin
      x_1_q     <= x_1_nxt_c;
      x_2_q     <= x_2_nxt_c;
      x_valid_q <= (x_1_nxt_c != x_1_q) | (x_2_nxt_c != x_2_q);
    end
  end

  assign x_1     = x_1_q;
  assign x_2     = x_2_q;
  assign x_valid = x_valid_q;
  assign press_1 = st_1.press;
  assign press_2 = st_2.press;

endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner
// Purpose: self-checking bench for btn_conditioner with DEBOUNCE_CYCLES=4 and
//          SYNC_STAGES=2. It applies a vector table, hand-written corner
//          sequences and random button activity. A behavioural model derives
//          the expected outputs from the raw-sample history.
module tb_btn_conditioner;

  localparam int unsigned D    = 4;
  localparam int unsigned S    = 2;
  localparam int          HIST = 8192;
  localparam int          NV   = 10;

  logic clk;
  logic rst;
  logic btn_1;
  logic btn_2;
  logic x_1;
  logic x_2;
  logic press_1;
  logic press_2;
  logic x_valid;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  btn_conditioner #(
    .DEBOUNCE_CYCLES (D),
    .SYNC_STAGES     (S)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .btn_1   (btn_1),
    .btn_2   (btn_2),
    .x_1     (x_1),
    .x_2     (x_2),
    .press_1 (press_1),
    .press_2 (press_2),
    .x_valid (x_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model. Edges are numbered from 1 after each reset. The level
  // seen after synchronisation just before edge j is the raw pin sampled at
  // edge j-S (0 before that). A channel's accepted level flips at edge n when
  // each of the last D edges, all after the previous flip, saw a synchronised
  // level different from the accepted one.
  // ---------------------------------------------------------------------------
  bit raw_h [2][HIST];
  int n_edge;
  int last_flip [2];
  bit stab      [2];
  bit rose_pend [2];
  bit ex_press  [2];
  bit ex_x      [2];
  bit ex_xv;

  function automatic bit synced_at(input int c, input int j);
    return (j - int'(S) >= 1) ? raw_h[c][j - int'(S)] : 1'b0;
  endfunction

  task automatic model_reset();
    n_edge = 0;
    ex_xv  = 1'b0;
    for (int c = 0; c < 2; c++) begin
      last_flip[c] = 0;
      stab[c]      = 1'b0;
      rose_pend[c] = 1'b0;
      ex_press[c]  = 1'b0;
      ex_x[c]      = 1'b0;
    end
  endtask

  task automatic model_step();
    bit nx [2];
    bit old;
    bit flip;
    if (n_edge >= HIST - 1) begin
      $display("FAIL model history overflow at edge %0d", n_edge);
      $fatal(1);
    end
    n_edge++;
    raw_h[0][n_edge] = btn_1;
    raw_h[1][n_edge] = btn_2;
    for (int c = 0; c < 2; c++) begin
      old  = stab[c];
      flip = (n_edge - last_flip[c]) >= int'(D);
      for (int j = n_edge - int'(D) + 1; j <= n_edge; j++)
        if (synced_at(c, j) == old) flip = 1'b0;
      ex_press[c]  = rose_pend[c];
      rose_pend[c] = flip && !old;
      if (flip) begin
        stab[c]      = !old;
        last_flip[c] = n_edge;
      end
`ifdef BTN_COND_TOGGLE_EN
      nx[c] = ex_x[c] ^ ex_press[c];
`else
      nx[c] = old;
`endif
    end
    ex_xv   = (nx[0] != ex_x[0]) || (nx[1] != ex_x[1]);
    ex_x[0] = nx[0];
    ex_x[1] = nx[1];
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else     model_step();
    end
  end

  // Compare every cycle against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check_bit("model x_1", x_1, ex_x[0]);
        check_bit("model x_2", x_2, ex_x[1]);
        check_bit("model press_1", press_1, ex_press[0]);
        check_bit("model press_2", press_2, ex_press[1]);
        check_bit("model x_valid", x_valid, ex_xv);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Directed vectors: hold {btn_1,btn_2} for 'hold' cycles and count pulses.
  // Expected operands are {x_1,x_2} at the end of each hold.
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic       b1;
    logic       b2;
    int         hold;
    logic [1:0] x_tog;
    logic [1:0] x_lvl;
    int         p1;
    int         p2;
    int         xv_tog;
    int         xv_lvl;
  } vec_t;

  vec_t tbl [NV];

  task automatic reset_dut();
    btn_1 = 1'b0;
    btn_2 = 1'b0;
    rst   = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_bit({tag, " x_1"}, x_1, 1'b0);
    check_bit({tag, " x_2"}, x_2, 1'b0);
    check_bit({tag, " press_1"}, press_1, 1'b0);
    check_bit({tag, " press_2"}, press_2, 1'b0);
    check_bit({tag, " x_valid"}, x_valid, 1'b0);
  endtask

  initial begin
    int   cp1;
    int   cp2;
    int   cxv;
    int   np;
    int   at;
    int   rem1;
    int   rem2;
    logic [1:0] exp_x;
    int   exp_xv;

    //                 b1    b2    hold x_tog  x_lvl  p1 p2 xvT xvL
    tbl[0] = '{1'b0, 1'b0, 20, 2'b00, 2'b00, 0, 0, 0, 0};
    tbl[1] = '{1'b1, 1'b0, 20, 2'b10, 2'b10, 1, 0, 1, 1};
    tbl[2] = '{1'b0, 1'b0, 20, 2'b10, 2'b00, 0, 0, 0, 1};
    tbl[3] = '{1'b1, 1'b1, 20, 2'b01, 2'b11, 1, 1, 1, 1};
    tbl[4] = '{1'b0, 1'b1, 20, 2'b01, 2'b01, 0, 0, 0, 1};
    tbl[5] = '{1'b0, 1'b0, 20, 2'b01, 2'b00, 0, 0, 0, 1};
    tbl[6] = '{1'b1, 1'b0,  3, 2'b01, 2'b00, 0, 0, 0, 0};
    tbl[7] = '{1'b0, 1'b0, 20, 2'b01, 2'b00, 0, 0, 0, 0};
    tbl[8] = '{1'b0, 1'b1,  4, 2'b01, 2'b00, 0, 0, 0, 0};
    tbl[9] = '{1'b0, 1'b0, 20, 2'b00, 2'b00, 0, 1, 1, 2};

    // Reset state, then idle with buttons low.
    rst   = 1'b1;
    btn_1 = 1'b0;
    btn_2 = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("in reset");
    rst    = 1'b0;
    chk_en = 1'b1;
    for (int s = 1; s <= 20; s++) begin
      @(negedge clk);
      check_all_zero("idle after reset");
    end

    // Vector table.
    reset_dut();
    for (int e = 0; e < NV; e++) begin
      btn_1 = tbl[e].b1;
      btn_2 = tbl[e].b2;
      cp1 = 0;
      cp2 = 0;
      cxv = 0;
      for (int s = 0; s < tbl[e].hold; s++) begin
        @(negedge clk);
        cp1 += int'(press_1);
        cp2 += int'(press_2);
        cxv += int'(x_valid);
      end
`ifdef BTN_COND_TOGGLE_EN
      exp_x  = tbl[e].x_tog;
      exp_xv = tbl[e].xv_tog;
`else
      exp_x  = tbl[e].x_lvl;
      exp_xv = tbl[e].xv_lvl;
`endif
      check_int($sformatf("vec%0d x", e), int'({x_1, x_2}), int'(exp_x));
      check_int($sformatf("vec%0d press_1 count", e), cp1, tbl[e].p1);
      check_int($sformatf("vec%0d press_2 count", e), cp2, tbl[e].p2);
      check_int($sformatf("vec%0d x_valid count", e), cxv, exp_xv);
    end

    // Clean press: exact latency of 7 cycles, then release.
    reset_dut();
    btn_1 = 1'b1;
    for (int s = 1; s <= 20; s++) begin
      @(negedge clk);
      check_bit($sformatf("clean press_1 c%0d", s), press_1, 1'(s == 7));
      check_bit($sformatf("clean x_valid c%0d", s), x_valid, 1'(s == 7));
      check_bit($sformatf("clean x_1 c%0d", s), x_1, 1'(s >= 7));
    end
    btn_1 = 1'b0;
    for (int s = 1; s <= 20; s++) begin
      @(negedge clk);
      check_bit($sformatf("release press_1 c%0d", s), press_1, 1'b0);
`ifdef BTN_COND_TOGGLE_EN
      check_bit($sformatf("release x_1 c%0d", s), x_1, 1'b1);
      check_bit($sformatf("release x_valid c%0d", s), x_valid, 1'b0);
`else
      check_bit($sformatf("release x_1 c%0d", s), x_1, 1'(s < 7));
      check_bit($sformatf("release x_valid c%0d", s), x_valid, 1'(s == 7));
`endif
    end

    // Bounce: toggle every 2 cycles for 12 cycles, then hold high.
    reset_dut();
    np = 0;
    at = -1;
    for (int i = 0; i < 40; i++) begin
      btn_1 = (i < 12) ? 1'(((i / 2) % 2) == 0) : 1'b1;
      @(negedge clk);
      if (press_1 === 1'b1) begin
        np++;
        at = i + 1;
      end
    end
    check_int("bounce press_1 count", np, 1);
    check_int("bounce press_1 cycle", at, 19);
    check_bit("bounce x_1", x_1, 1'b1);

    // Asynchronous reset mid-cycle clears outputs at once.
    reset_dut();
    btn_1 = 1'b1;
    repeat (8) @(negedge clk);
    check_bit("pre-reset x_1", x_1, 1'b1);
    #2 rst = 1'b1;
    #1 check_all_zero("async reset");
    btn_1 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int s = 1; s <= 20; s++) begin
      @(negedge clk);
      check_all_zero("after async reset");
    end

    // Reset while the counter sits at 3, button held through release.
    reset_dut();
    btn_1 = 1'b1;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    check_all_zero("mid-count reset");
    rst = 1'b0;
    for (int s = 1; s <= 10; s++) begin
      @(negedge clk);
      check_bit($sformatf("mid-count press_1 c%0d", s), press_1, 1'(s == 7));
    end

    // Random activity with occasional mid-cycle resets, checked by the model.
    reset_dut();
    rem1 = 0;
    rem2 = 0;
    for (int i = 0; i < 1500; i++) begin
      if (rem1 == 0) begin
        btn_1 = 1'($urandom_range(0, 1));
        rem1  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4))
                                            : int'($urandom_range(4, 14));
      end
      if (rem2 == 0) begin
        btn_2 = 1'($urandom_range(0, 1));
        rem2  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4))
                                            : int'($urandom_range(4, 14));
      end
      rem1--;
      rem2--;
      if ($urandom_range(0, 399) == 0) begin
        #2 rst = 1'b1;
        #5 rst = 1'b0;
      end
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
